ps2_key_tracker: RTL and testbench



---
 rtl/ps2_pkg.sv | 16 +
 rtl/ps2_scan2ascii.sv | 59 +++++
 rtl/ps2_key_tracker.sv | 90 +++++++++
 tb/tb_ps2_key_tracker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix/status byte values and the key tracker state set.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_BAT = 8'hAA;
    localparam logic [7:0] PS2_ACK = 8'hFA;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } ps2_state_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Set-2 scan code to unshifted lowercase ASCII; extended codes have no ASCII value.
module ps2_scan2ascii
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    // Table lookup of letters, digits, space, enter and backspace; everything else is 0x00
    always_comb begin
        ascii = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: ascii = 8'h61;
                8'h32: ascii = 8'h62;
                8'h21: ascii = 8'h63;
                8'h23: ascii = 8'h64;
                8'h24: ascii = 8'h65;
                8'h2B: ascii = 8'h66;
                8'h34: ascii = 8'h67;
                8'h33: ascii = 8'h68;
                8'h43: ascii = 8'h69;
                8'h3B: ascii = 8'h6A;
                8'h42: ascii = 8'h6B;
                8'h4B: ascii = 8'h6C;
                8'h3A: ascii = 8'h6D;
                8'h31: ascii = 8'h6E;
                8'h44: ascii = 8'h6F;
                8'h4D: ascii = 8'h70;
                8'h15: ascii = 8'h71;
                8'h2D: ascii = 8'h72;
                8'h1B: ascii = 8'h73;
                8'h2C: ascii = 8'h74;
                8'h3C: ascii = 8'h75;
                8'h2A: ascii = 8'h76;
                8'h1D: ascii = 8'h77;
                8'h22: ascii = 8'h78;
                8'h35: ascii = 8'h79;
                8'h1A: ascii = 8'h7A;
                8'h45: ascii = 8'h30;
                8'h16: ascii = 8'h31;
                8'h1E: ascii = 8'h32;
                8'h26: ascii = 8'h33;
                8'h25: ascii = 8'h34;
                8'h2E: ascii = 8'h35;
                8'h36: ascii = 8'h36;
                8'h3D: ascii = 8'h37;
                8'h3E: ascii = 8'h38;
                8'h46: ascii = 8'h39;
                8'h29: ascii = 8'h20;
                8'h5A: ascii = 8'h0D;
                8'h66: ascii = 8'h08;
                default: ascii = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns the raw PS/2 byte stream into held-key state and a count of distinct presses.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter bit IGNORE_REPEAT = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       code_in,
    input  logic             code_valid,
    output logic [7:0]       key_code,
    output logic [7:0]       ascii,
    output logic             key_ext,
    output logic             key_down,
    output logic [CNT_W-1:0] key_count
);

    ps2_state_t       r_state;
    logic [7:0]       r_keyCode;
    logic [7:0]       r_ascii;
    logic             r_keyExt;
    logic             r_keyDown;
    logic [CNT_W-1:0] r_keyCount;

    logic [7:0]       w_lookupAscii;
    logic             w_makeExt;
    logic             w_breakExt;
    logic             w_isStatus;
    logic             w_isRepeat;
    logic             w_isRelease;

    // A make seen in EXT carries the extended flag; a break in EXT_BRK releases an extended key
    assign w_makeExt   = (r_state == EXT);
    assign w_breakExt  = (r_state == EXT_BRK);
    assign w_isStatus  = (code_in == 8'h00) || (code_in == PS2_BAT) || (code_in == PS2_ACK);
    assign w_isRepeat  = IGNORE_REPEAT && r_keyDown && (code_in == r_keyCode) && (r_keyExt == w_makeExt);
    assign w_isRelease = r_keyDown && (code_in == r_keyCode) && (r_keyExt == w_breakExt);

    ps2_scan2ascii u_scan2ascii (
        .code  (code_in),
        .ext   (w_makeExt),
        .ascii (w_lookupAscii)
    );

    // Prefix-decoding FSM plus the registered key state it updates on each consumed byte
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_keyCode  <= 8'h00;
            r_ascii    <= 8'h00;
            r_keyExt   <= 1'b0;
            r_keyDown  <= 1'b0;
            r_keyCount <= '0;
        end else if (code_valid) begin
            case (r_state)
                IDLE, EXT: begin
                    if (code_in == PS2_BRK) begin
                        r_state <= (r_state == EXT) ? EXT_BRK : BRK;
                    end else if (code_in == PS2_EXT) begin
                        r_state <= EXT;
                    end else if (!w_isStatus) begin
                        r_state <= IDLE;
                        if (!w_isRepeat) begin
                            r_keyCode  <= code_in;
                            r_keyExt   <= w_makeExt;
                            r_ascii    <= w_lookupAscii;
                            r_keyDown  <= 1'b1;
                            r_keyCount <= r_keyCount + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                BRK, EXT_BRK: begin
                    if (w_isRelease) begin
                        r_keyDown <= 1'b0;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign key_code  = r_keyCode;
    assign ascii     = r_ascii;
    assign key_ext   = r_keyExt;
    assign key_down  = r_keyDown;
    assign key_count = r_keyCount;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus queues expected state, a monitor compares.
module tb_ps2_key_tracker;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] asc;
        logic       ext;
        logic       down;
        logic [7:0] cnt;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic [7:0] code_in;
    logic       code_valid;
    logic [7:0] key_code;
    logic [7:0] ascii;
    logic       key_ext;
    logic       key_down;
    logic [7:0] key_count;

    exp_t  expQ[$];
    string nameQ[$];
    int    checks   = 0;
    int    failures = 0;
    bit    sampleEvt = 1'b0;
    bit    stimDone  = 1'b0;
    bit    timedOut  = 1'b0;

    ps2_key_tracker #(.CNT_W(8), .IGNORE_REPEAT(1'b1)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .code_in    (code_in),
        .code_valid (code_valid),
        .key_code   (key_code),
        .ascii      (ascii),
        .key_ext    (key_ext),
        .key_down   (key_down),
        .key_count  (key_count)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Marks every edge on which the DUT consumed a byte or a reset, so the monitor knows to look
    always @(posedge clk) begin
        sampleEvt <= (code_valid === 1'b1) || (resetn === 1'b0);
    end

    // Drive one strobed byte at the falling edge and queue the state expected after it
    task automatic applyStimulus(input string nm, input logic [7:0] b, input logic [7:0] eCode,
                                 input logic [7:0] eAsc, input logic eExt, input logic eDown,
                                 input logic [7:0] eCnt);
        exp_t e;
        @(negedge clk);
        code_in    = b;
        code_valid = 1'b1;
        e.code = eCode;
        e.asc  = eAsc;
        e.ext  = eExt;
        e.down = eDown;
        e.cnt  = eCnt;
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    // Drop the strobe for one cycle
    task automatic applyIdle();
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    // One-cycle reset, optionally with a simultaneous strobe that must lose
    task automatic applyReset(input logic [7:0] b, input logic strobe);
        exp_t e;
        @(negedge clk);
        resetn     = 1'b0;
        code_in    = b;
        code_valid = strobe;
        e = '0;
        expQ.push_back(e);
        nameQ.push_back(strobe ? "resetWins" : "reset");
        @(negedge clk);
        resetn     = 1'b1;
        code_valid = 1'b0;
    endtask

    // Compare the DUT outputs against one scoreboard entry
    task automatic checkOutput(input string nm, input exp_t e);
        checks++;
        if (key_code !== e.code || ascii !== e.asc || key_ext !== e.ext ||
            key_down !== e.down || key_count !== e.cnt) begin
            failures++;
            $display("[TB] FAIL %s got code=%h ascii=%h ext=%b down=%b cnt=%h want code=%h ascii=%h ext=%b down=%b cnt=%h",
                     nm, key_code, ascii, key_ext, key_down, key_count,
                     e.code, e.asc, e.ext, e.down, e.cnt);
        end
    endtask

    // Monitor: pops one expectation per consumed byte/reset and finishes the run
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (sampleEvt) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedEvent got event want none queued");
            end else begin
                e  = expQ.pop_front();
                nm = nameQ.pop_front();
                checkOutput(nm, e);
            end
        end
        if (stimDone || timedOut) begin
            if (timedOut) begin
                failures++;
                $display("[TB] FAIL timeout got time limit reached want stimulus complete");
            end
            checks++;
            if (expQ.size() != 0) begin
                failures++;
                $display("[TB] FAIL queueDrain got %0d pending want 0", expQ.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    // Time bound on the whole run
    initial begin
        #200000;
        timedOut = 1'b1;
    end

    // Directed stimulus with hand-computed expectations
    initial begin
        logic [7:0] k;
        logic [7:0] a;
        logic [7:0] c;
        string      nm;
        resetn     = 1'b1;
        code_valid = 1'b0;
        code_in    = 8'h00;

        applyReset(8'h00, 1'b0);

        applyStimulus("make1C", 8'h1C, 8'h1C, 8'h61, 1'b0, 1'b1, 8'd1);
        applyIdle();
        for (int i = 0; i < 3; i++)
            applyStimulus("repeat1C", 8'h1C, 8'h1C, 8'h61, 1'b0, 1'b1, 8'd1);
        applyStimulus("brkPfx1C", 8'hF0, 8'h1C, 8'h61, 1'b0, 1'b1, 8'd1);
        applyStimulus("brk1C", 8'h1C, 8'h1C, 8'h61, 1'b0, 1'b0, 8'd1);
        applyIdle();

        applyStimulus("extPfx", 8'hE0, 8'h1C, 8'h61, 1'b0, 1'b0, 8'd1);
        applyStimulus("extMake75", 8'h75, 8'h75, 8'h00, 1'b1, 1'b1, 8'd2);
        applyStimulus("brkPfx75", 8'hF0, 8'h75, 8'h00, 1'b1, 1'b1, 8'd2);
        applyStimulus("brkNoExt75", 8'h75, 8'h75, 8'h00, 1'b1, 1'b1, 8'd2);
        applyStimulus("extBrkE0", 8'hE0, 8'h75, 8'h00, 1'b1, 1'b1, 8'd2);
        applyStimulus("extBrkF0", 8'hF0, 8'h75, 8'h00, 1'b1, 1'b1, 8'd2);
        applyStimulus("extBrk75", 8'h75, 8'h75, 8'h00, 1'b1, 1'b0, 8'd2);
        applyIdle();

        applyStimulus("make1Cagain", 8'h1C, 8'h1C, 8'h61, 1'b0, 1'b1, 8'd3);
        applyStimulus("replace32", 8'h32, 8'h32, 8'h62, 1'b0, 1'b1, 8'd4);
        applyStimulus("brkPfxOther", 8'hF0, 8'h32, 8'h62, 1'b0, 1'b1, 8'd4);
        applyStimulus("brkOther1C", 8'h1C, 8'h32, 8'h62, 1'b0, 1'b1, 8'd4);
        applyIdle();

        applyStimulus("batIdle", 8'hAA, 8'h32, 8'h62, 1'b0, 1'b1, 8'd4);
        applyStimulus("extPfx2", 8'hE0, 8'h32, 8'h62, 1'b0, 1'b1, 8'd4);
        applyStimulus("ackInExt", 8'hFA, 8'h32, 8'h62, 1'b0, 1'b1, 8'd4);
        applyStimulus("extMake1C", 8'h1C, 8'h1C, 8'h00, 1'b1, 1'b1, 8'd5);
        applyStimulus("extBrkE0b", 8'hE0, 8'h1C, 8'h00, 1'b1, 1'b1, 8'd5);
        applyStimulus("extBrkF0b", 8'hF0, 8'h1C, 8'h00, 1'b1, 1'b1, 8'd5);
        applyStimulus("extBrk1C", 8'h1C, 8'h1C, 8'h00, 1'b1, 1'b0, 8'd5);
        applyStimulus("zeroIdle", 8'h00, 8'h1C, 8'h00, 1'b1, 1'b0, 8'd5);
        applyStimulus("extExtA", 8'hE0, 8'h1C, 8'h00, 1'b1, 1'b0, 8'd5);
        applyStimulus("extExtB", 8'hE0, 8'h1C, 8'h00, 1'b1, 1'b0, 8'd5);
        applyStimulus("extMake5A", 8'h5A, 8'h5A, 8'h00, 1'b1, 1'b1, 8'd6);
        applyStimulus("plainMake5A", 8'h5A, 8'h5A, 8'h0D, 1'b0, 1'b1, 8'd7);
        applyStimulus("brkPfx5A", 8'hF0, 8'h5A, 8'h0D, 1'b0, 1'b1, 8'd7);
        applyStimulus("brk5A", 8'h5A, 8'h5A, 8'h0D, 1'b0, 1'b0, 8'd7);
        applyStimulus("make66", 8'h66, 8'h66, 8'h08, 1'b0, 1'b1, 8'd8);
        applyStimulus("make29", 8'h29, 8'h29, 8'h20, 1'b0, 1'b1, 8'd9);
        applyIdle();

        applyStimulus("brkPfxBeforeReset", 8'hF0, 8'h29, 8'h20, 1'b0, 1'b1, 8'd9);
        applyIdle();
        applyReset(8'h1C, 1'b1);
        applyStimulus("makeAfterReset45", 8'h45, 8'h45, 8'h30, 1'b0, 1'b1, 8'd1);
        applyIdle();

        applyReset(8'h00, 1'b0);
        for (int i = 0; i < 256; i++) begin
            k  = i[0] ? 8'h32 : 8'h1C;
            a  = i[0] ? 8'h62 : 8'h61;
            c  = 8'(i + 1);
            nm = (i == 254) ? "wrapMake255" : (i == 255) ? "wrapMake256" : "wrapMake";
            applyStimulus(nm, k, k, a, 1'b0, 1'b1, c);
            applyStimulus("wrapBrkPfx", 8'hF0, k, a, 1'b0, 1'b1, c);
            applyStimulus("wrapBrk", k, k, a, 1'b0, 1'b0, c);
        end
        applyIdle();

        repeat (3) @(negedge clk);
        stimDone = 1'b1;
    end

endmodule
